// File: rtl/rcon_gen_if.sv
// Request/response bundle between the key-expansion FSM and the round-constant
// generator. The key-expansion side is the master: it issues load/step requests
// and samples dout/idx while ready is high.
interface rcon_gen_if #(
    parameter int WORD_W = 32,
    parameter int IDX_W  = 4
);
    logic              load;
    logic [IDX_W-1:0]  load_idx;
    logic              step_fwd;
    logic              step_bwd;
    logic [WORD_W-1:0] dout;
    logic [IDX_W-1:0]  idx;
    logic              ready;
    logic              err;

    modport master (
        output load, load_idx, step_fwd, step_bwd,
        input  dout, idx, ready, err
    );

    modport slave (
        input  load, load_idx, step_fwd, step_bwd,
        output dout, idx, ready, err
    );
endinterface

// File: rtl/rcon_gen.sv
// AES round-constant generator. Instead of a stored Rcon table the constant is
// produced by repeated GF(2^8) doubling (xtime). Forward steps serve the
// encryption key schedule, backward steps (inverse xtime) serve the inverse
// schedule, and a load seeds a walk from index 0 up to an arbitrary index.
module rcon_gen #(
    parameter int         WORD_W   = 32,
    parameter int         NUM_RCON = 10,
    parameter logic [7:0] POLY     = 8'h1B,
    parameter int         IDX_W    = 4
) (
    input logic        clk,
    input logic        rst,
    rcon_gen_if.slave  bus
);

    typedef enum logic {
        READY = 1'b0,
        SEEK  = 1'b1
    } state_t;

    localparam logic [IDX_W:0]   NUM_L    = (IDX_W+1)'(NUM_RCON);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RCON - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t           state, state_n;
    logic [7:0]       rc, rc_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic [IDX_W-1:0] target, target_n;
    logic             err_q, err_n;
    logic             load_bad;
    logic [IDX_W-1:0] idx_inc;

    // Multiply by x in GF(2^8) with the configured reduction term.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? POLY : 8'h00);
    endfunction

    // Divide by x; relies on POLY[0]=1 so an odd value must have been reduced.
    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        return b[0] ? (((b ^ POLY) >> 1) | 8'h80) : (b >> 1);
    endfunction

    assign load_bad = ({1'b0, bus.load_idx} >= NUM_L);
    assign idx_inc  = idx_q + IDX_ONE;

    // Registered state: everything the outside world sees comes from these flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= READY;
            rc     <= 8'h01;
            idx_q  <= '0;
            target <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            rc     <= rc_n;
            idx_q  <= idx_n;
            target <= target_n;
            err_q  <= err_n;
        end
    end

    // Request arbitration and seek progress; load outranks steps, a rejected
    // request only raises err for one cycle and leaves rc/idx untouched.
    always_comb begin
        state_n  = state;
        rc_n     = rc;
        idx_n    = idx_q;
        target_n = target;
        err_n    = 1'b0;

        case (state)
            READY: begin
                if (bus.load) begin
                    if (load_bad) begin
                        err_n = 1'b1;
                    end else begin
                        rc_n     = 8'h01;
                        idx_n    = '0;
                        target_n = bus.load_idx;
                        if (bus.load_idx != '0) begin
                            state_n = SEEK;
                        end
                    end
                end else if (bus.step_fwd && !bus.step_bwd) begin
                    if (idx_q == LAST_IDX) begin
                        err_n = 1'b1;
                    end else begin
                        rc_n  = xtime(rc);
                        idx_n = idx_inc;
                    end
                end else if (bus.step_bwd && !bus.step_fwd) begin
                    if (idx_q == '0) begin
                        err_n = 1'b1;
                    end else begin
                        rc_n  = inv_xtime(rc);
                        idx_n = idx_q - IDX_ONE;
                    end
                end
            end

            SEEK: begin
                if (bus.load && !load_bad) begin
                    rc_n     = 8'h01;
                    idx_n    = '0;
                    target_n = bus.load_idx;
                    state_n  = (bus.load_idx == '0) ? READY : SEEK;
                end else begin
                    err_n = bus.load;
                    rc_n  = xtime(rc);
                    idx_n = idx_inc;
                    if (idx_inc == target) begin
                        state_n = READY;
                    end
                end
            end

            default: begin
                state_n = READY;
            end
        endcase
    end

    // Place the constant in the top byte of the output word, zeros below.
    always_comb begin
        bus.dout                 = '0;
        bus.dout[WORD_W-1 -: 8]  = rc;
    end

    assign bus.idx   = idx_q;
    assign bus.ready = (state == READY);
    assign bus.err   = err_q;

endmodule
